// File: rtl/death_sequencer.sv
// death_sequencer
//   Collision-to-life-loss controller for the Pacman game core. Each frame it
//   tests Pacman against every ghost. On a lethal hit it pulses fail to the
//   life counter and freezes play for the death animation. After the animation
//   it respawns Pacman with an invulnerability window. If the hit used the last
//   life it enters game over, and a start request then reloads the life counter.
//
// Ports
//   clock        system clock
//   Reset_n      asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        restart request, honoured only in game over
//   pac_xy       Pacman position {x[9:0], y[9:0]}
//   ghost_xy     ghost i at [20i+19:20i], same format as pac_xy
//   LC           lives remaining, from the life counter
//   fail         one-cycle pulse to the life counter's fail input
//   lc_reload    one-cycle pulse to the life counter's reset input
//   freeze       halts all sprite movement
//   respawn      one-cycle pulse, the position logic reloads start positions
//   grace        high during the invulnerability window
//   game_over    high while in game over
//   anim_frame   death animation frame index (0 outside the death animation)
//
// Optional feature, macro FRIGHT_EAT_EN:
//   adds ghost_fright[NUM_GHOSTS-1:0] (in) and ghost_eaten[NUM_GHOSTS-1:0]
//   (out). A frightened ghost touched on a frame tick is eaten (one-cycle
//   ghost_eaten pulse) instead of killing Pacman, unless a non-frightened ghost
//   collides in the same frame.

module death_sequencer #(
    parameter int unsigned NUM_GHOSTS   = 4,
    parameter int unsigned HIT_RADIUS   = 8,
    parameter int unsigned DEATH_FRAMES = 64,
    parameter int unsigned GRACE_FRAMES = 120
) (
    input  logic                    clock,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic                    start,
    input  logic [19:0]             pac_xy,
    input  logic [20*NUM_GHOSTS-1:0] ghost_xy,
    input  logic [1:0]              LC,
`ifdef FRIGHT_EAT_EN
    input  logic [NUM_GHOSTS-1:0]   ghost_fright,
    output logic [NUM_GHOSTS-1:0]   ghost_eaten,
`endif
    output logic                    fail,
    output logic                    lc_reload,
    output logic                    freeze,
    output logic                    respawn,
    output logic                    grace,
    output logic                    game_over,
    output logic [2:0]              anim_frame
);

    localparam int unsigned MAX_FRAMES = (DEATH_FRAMES > GRACE_FRAMES) ? DEATH_FRAMES : GRACE_FRAMES;
    localparam int unsigned CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CW-1:0]   DEATH_LAST = CW'(DEATH_FRAMES - 1);
    localparam logic [CW-1:0]   GRACE_LAST = CW'(GRACE_FRAMES - 1);
    localparam logic [11:0]     RADIUS     = 12'(HIT_RADIUS);
    localparam logic [CW+2:0]   ANIM_DEN   = (CW+3)'(DEATH_FRAMES);

    typedef enum logic [2:0] {
        S_PLAY,
        S_HIT,
        S_DYING,
        S_RESPAWN,
        S_GRACE,
        S_GAME_OVER
    } state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 last_life, last_life_nx;

    logic [NUM_GHOSTS-1:0] hit_vec;
    logic [NUM_GHOSTS-1:0] lethal_vec;
    logic                  hit_any;

`ifdef FRIGHT_EAT_EN
    logic [NUM_GHOSTS-1:0] eat_vec;
    logic [NUM_GHOSTS-1:0] eaten_q, eaten_nx;
`endif

    // Unsigned distance; no wrap-around across the 0/1023 screen edge.
    function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
        absdiff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
            hit_vec[i] = ({1'b0, absdiff(pac_xy[19:10], ghost_xy[20*i+10 +: 10])} < RADIUS) &&
                         ({1'b0, absdiff(pac_xy[9:0],   ghost_xy[20*i    +: 10])} < RADIUS);
        end
    end

`ifdef FRIGHT_EAT_EN
    // Any non-frightened contact is lethal and overrides eating.
    assign lethal_vec = hit_vec & ~ghost_fright;
    assign eat_vec    = hit_vec &  ghost_fright;
    assign ghost_eaten = eaten_q;
`else
    assign lethal_vec = hit_vec;
`endif

    assign hit_any = |lethal_vec;

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_PLAY;
            cnt       <= '0;
            last_life <= 1'b0;
`ifdef FRIGHT_EAT_EN
            eaten_q   <= '0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last_life <= last_life_nx;
`ifdef FRIGHT_EAT_EN
            eaten_q   <= eaten_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        last_life_nx = last_life;
        fail         = 1'b0;
        lc_reload    = 1'b0;
        freeze       = 1'b0;
        respawn      = 1'b0;
        grace        = 1'b0;
        game_over    = 1'b0;
        anim_frame   = 3'd0;
`ifdef FRIGHT_EAT_EN
        eaten_nx     = '0;
`endif

        case (state)
            S_PLAY: begin
                if (frame_tick) begin
                    if (hit_any) begin
                        state_nx = S_HIT;
                    end
`ifdef FRIGHT_EAT_EN
                    else begin
                        eaten_nx = eat_vec;
                    end
`endif
                end
            end

            S_HIT: begin
                fail   = 1'b1;
                freeze = 1'b1;
                // LC has not yet been decremented by this fail pulse.
                last_life_nx = (LC == 2'd0);
                cnt_nx       = '0;
                state_nx     = S_DYING;
            end

            S_DYING: begin
                freeze = 1'b1;
                // Eight animation frames spread over DEATH_FRAMES; reduces to
                // cnt[5:3] for 64 frames.
                anim_frame = 3'({cnt, 3'b000} / ANIM_DEN);
                if (frame_tick) begin
                    if (cnt == DEATH_LAST) begin
                        cnt_nx   = '0;
                        state_nx = last_life ? S_GAME_OVER : S_RESPAWN;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            S_RESPAWN: begin
                respawn  = 1'b1;
                freeze   = 1'b1;
                cnt_nx   = '0;
                state_nx = S_GRACE;
            end

            S_GRACE: begin
                grace = 1'b1;
                if (frame_tick) begin
                    if (cnt == GRACE_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_PLAY;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end

            S_GAME_OVER: begin
                game_over = 1'b1;
                freeze    = 1'b1;
                if (start) begin
                    lc_reload = 1'b1;
                    state_nx  = S_RESPAWN;
                end
            end

            default: begin
                cnt_nx   = '0;
                state_nx = S_PLAY;
            end
        endcase
    end

endmodule

// File: tb/tb_death_sequencer.sv
module tb_death_sequencer;

    localparam int NG = 4;
    localparam int HR = 8;
    localparam int DF = 64;
    localparam int GF = 120;

    logic               clock = 1'b0;
    logic               Reset_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start = 1'b0;
    logic [19:0]        pac_xy = '0;
    logic [20*NG-1:0]   ghost_xy = '0;
    logic [1:0]         LC = 2'd2;
    logic               fail, lc_reload, freeze, respawn, grace, game_over;
    logic [2:0]         anim_frame;
`ifdef FRIGHT_EAT_EN
    logic [NG-1:0]      ghost_fright = '0;
    logic [NG-1:0]      ghost_eaten;
`endif

    logic [8:0]         outs;
    assign outs = {fail, lc_reload, freeze, respawn, grace, game_over, anim_frame};

    death_sequencer #(
        .NUM_GHOSTS  (NG),
        .HIT_RADIUS  (HR),
        .DEATH_FRAMES(DF),
        .GRACE_FRAMES(GF)
    ) dut (
        .clock      (clock),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .start      (start),
        .pac_xy     (pac_xy),
        .ghost_xy   (ghost_xy),
        .LC         (LC),
`ifdef FRIGHT_EAT_EN
        .ghost_fright(ghost_fright),
        .ghost_eaten (ghost_eaten),
`endif
        .fail       (fail),
        .lc_reload  (lc_reload),
        .freeze     (freeze),
        .respawn    (respawn),
        .grace      (grace),
        .game_over  (game_over),
        .anim_frame (anim_frame)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the sequence is tracked as "what is pending / how many
    // frames remain" rather than as a state machine.
    int            m_hit_pend, m_dying_left, m_resp_pend, m_grace_left, m_over, m_last_life;
    logic [NG-1:0] m_eaten;
    logic [8:0]    exp_outs;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [NG-1:0] model_hits();
        logic [NG-1:0] r;
        int px, py, gx, gy;
        r  = '0;
        px = int'(pac_xy[19:10]);
        py = int'(pac_xy[9:0]);
        for (int g = 0; g < NG; g++) begin
            gx = int'(ghost_xy[20*g+10 +: 10]);
            gy = int'(ghost_xy[20*g    +: 10]);
            r[g] = (iabs(px - gx) < HR) && (iabs(py - gy) < HR);
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_hit_pend = 0; m_dying_left = 0; m_resp_pend = 0;
        m_grace_left = 0; m_over = 0; m_last_life = 0; m_eaten = '0;
    endfunction

    function automatic void model_outputs();
        logic e_dying;
        int   anim;
        e_dying = (m_dying_left > 0);
        anim    = e_dying ? ((DF - m_dying_left) * 8 / DF) : 0;
        exp_outs = {m_hit_pend != 0,
                    (m_over != 0) && start,
                    (m_hit_pend != 0) || e_dying || (m_resp_pend != 0) || (m_over != 0),
                    m_resp_pend != 0,
                    m_grace_left > 0,
                    m_over != 0,
                    3'(anim)};
    endfunction

    function automatic void model_update();
        logic [NG-1:0] hv, lethal;
        m_eaten = '0;
        if (m_hit_pend != 0) begin
            m_hit_pend   = 0;
            m_last_life  = (LC == 2'd0);
            m_dying_left = DF;
        end else if (m_dying_left > 0) begin
            if (frame_tick) begin
                m_dying_left--;
                if (m_dying_left == 0) begin
                    if (m_last_life != 0) m_over = 1;
                    else                  m_resp_pend = 1;
                end
            end
        end else if (m_resp_pend != 0) begin
            m_resp_pend  = 0;
            m_grace_left = GF;
        end else if (m_grace_left > 0) begin
            if (frame_tick) m_grace_left--;
        end else if (m_over != 0) begin
            if (start) begin
                m_over      = 0;
                m_resp_pend = 1;
            end
        end else if (frame_tick) begin
            hv = model_hits();
`ifdef FRIGHT_EAT_EN
            lethal = hv & ~ghost_fright;
            if (lethal != '0) m_hit_pend = 1;
            else              m_eaten = hv & ghost_fright;
`else
            lethal = hv;
            if (lethal != '0) m_hit_pend = 1;
`endif
        end
    endfunction

    task automatic advance();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic place_pac(input int x, input int y);
        pac_xy = {10'(x), 10'(y)};
    endtask

    task automatic place_ghost(input int g, input int x, input int y);
        ghost_xy[20*g +: 20] = {10'(x), 10'(y)};
    endtask

    task automatic park_ghosts();
        for (int g = 0; g < NG; g++) place_ghost(g, 700 + 60*g, 800);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1; advance();
            frame_tick = 1'b0; advance();
        end
    endtask

    task automatic do_reset();
        frame_tick = 1'b0;
        start      = 1'b0;
        Reset_n    = 1'b0;
        model_reset();
        #2;
        Reset_n = 1'b1;
        advance();
    endtask

    task automatic test_reset();
        park_ghosts();
        place_pac(100, 100);
        do_reset();
        #1;
        vectors++;
        if (outs !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", outs, 9'd0);
        end
`ifdef FRIGHT_EAT_EN
        vectors++;
        if (ghost_eaten !== '0) begin
            miscompares++;
            $display("FAIL reset_eaten: got %b want 0", ghost_eaten);
        end
`endif
    endtask

    task automatic test_hit_respawn();
        int n;
        bit done;
        do_reset();
        LC = 2'd2;
        park_ghosts();
        place_pac(100, 100);
        place_ghost(0, 104, 103);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_fail: got fail=%b freeze=%b want 1 1", fail, freeze);
        end
        park_ghosts();
        advance(); #1;
        vectors++;
        if (fail !== 1'b0 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_fail_width: got fail=%b freeze=%b want 0 1", fail, freeze);
        end
        n = 0; done = 0;
        while (!done && n < 200) begin
            frame_tick = 1'b1; advance(); n++; frame_tick = 1'b0; #1;
            if (n == 40) begin
                vectors++;
                if (anim_frame !== 3'd5) begin
                    miscompares++;
                    $display("FAIL anim_frame_40: got %0d want 5", anim_frame);
                end
            end
            if (respawn === 1'b1) done = 1;
            else advance();
        end
        vectors++;
        if (!done || n != DF) begin
            miscompares++;
            $display("FAIL respawn_delay: got %0d ticks (seen=%0d) want %0d", n, done, DF);
        end
        advance(); #1;
        vectors++;
        if (grace !== 1'b1 || freeze !== 1'b0 || respawn !== 1'b0) begin
            miscompares++;
            $display("FAIL grace_entry: got grace=%b freeze=%b respawn=%b want 1 0 0", grace, freeze, respawn);
        end
        n = 0; done = 0;
        while (!done && n < 300) begin
            frame_tick = 1'b1; advance(); n++; frame_tick = 1'b0; #1;
            if (grace !== 1'b1) done = 1;
            else advance();
        end
        vectors++;
        if (!done || n != GF) begin
            miscompares++;
            $display("FAIL grace_length: got %0d ticks (ended=%0d) want %0d", n, done, GF);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        LC = 2'd2;
        park_ghosts();
        place_pac(100, 100);
        place_ghost(0, 108, 100);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b0 || freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_dx8: got fail=%b freeze=%b want 0 0", fail, freeze);
        end
        place_ghost(0, 100, 92);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_dy8: got %b want 0", fail);
        end
        place_pac(2, 500);
        place_ghost(0, 1021, 500);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b0) begin
            miscompares++;
            $display("FAIL no_wrap: got %b want 0", fail);
        end
        place_pac(100, 100);
        place_ghost(0, 107, 93);
        for (int i = 0; i < 5; i++) begin
            advance(); #1;
            vectors++;
            if (fail !== 1'b0) begin
                miscompares++;
                $display("FAIL no_tick_hit cycle %0d: got %b want 0", i, fail);
            end
        end
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1) begin
            miscompares++;
            $display("FAIL hit_dx7_dy7: got %b want 1", fail);
        end
    endtask

    task automatic test_last_life();
        do_reset();
        LC = 2'd0;
        park_ghosts();
        place_pac(400, 400);
        start = 1'b1; #1;
        vectors++;
        if (lc_reload !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_play: got lc_reload=%b want 0", lc_reload);
        end
        advance();
        start = 1'b0;
        place_ghost(3, 395, 405);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1) begin
            miscompares++;
            $display("FAIL last_life_fail: got %b want 1", fail);
        end
        park_ghosts();
        advance();
        run_ticks(DF);
        #1;
        vectors++;
        if (game_over !== 1'b1 || freeze !== 1'b1 || respawn !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over_entry: got go=%b freeze=%b respawn=%b want 1 1 0", game_over, freeze, respawn);
        end
        place_ghost(3, 400, 400);
        run_ticks(3);
        #1;
        vectors++;
        if (game_over !== 1'b1 || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over_hold: got go=%b fail=%b want 1 0", game_over, fail);
        end
        park_ghosts();
        start = 1'b1; #1;
        vectors++;
        if (lc_reload !== 1'b1) begin
            miscompares++;
            $display("FAIL lc_reload_pulse: got %b want 1", lc_reload);
        end
        advance(); start = 1'b0; #1;
        vectors++;
        if (respawn !== 1'b1 || lc_reload !== 1'b0 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_respawn: got respawn=%b reload=%b go=%b want 1 0 0", respawn, lc_reload, game_over);
        end
        advance(); #1;
        vectors++;
        if (grace !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_grace: got %b want 1", grace);
        end
        LC = 2'd2;
    endtask

    task automatic test_grace_ignore();
        do_reset();
        LC = 2'd1;
        park_ghosts();
        place_pac(300, 300);
        place_ghost(1, 303, 295);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1) begin
            miscompares++;
            $display("FAIL grace_setup_fail: got %b want 1", fail);
        end
        advance();
        run_ticks(DF);
        #1;
        vectors++;
        if (grace !== 1'b1) begin
            miscompares++;
            $display("FAIL grace_setup_grace: got %b want 1", grace);
        end
        for (int i = 0; i < GF; i++) begin
            frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
            vectors++;
            if (fail !== 1'b0) begin
                miscompares++;
                $display("FAIL grace_overlap tick %0d: got fail=%b want 0", i + 1, fail);
            end
            advance();
        end
        #1;
        vectors++;
        if (grace !== 1'b0) begin
            miscompares++;
            $display("FAIL grace_exit: got %b want 0", grace);
        end
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1) begin
            miscompares++;
            $display("FAIL post_grace_hit: got %b want 1", fail);
        end
    endtask

    task automatic test_multi_hit();
        int pulses;
        do_reset();
        LC = 2'd2;
        park_ghosts();
        place_pac(512, 256);
        place_ghost(0, 510, 250);
        place_ghost(1, 518, 256);
        place_ghost(3, 512, 262);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (fail === 1'b1) pulses++;
            frame_tick = (i % 2 == 1);
            advance();
        end
        frame_tick = 1'b0;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL multi_hit_pulses: got %0d want 1", pulses);
        end
        #1;
        vectors++;
        if (freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_dying_freeze: got %b want 1", freeze);
        end
        #1;
        Reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (outs !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_mid_dying: got %b want %b", outs, 9'd0);
        end
        Reset_n = 1'b1;
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (fail !== 1'b1) begin
            miscompares++;
            $display("FAIL play_after_reset: got %b want 1", fail);
        end
    endtask

`ifdef FRIGHT_EAT_EN
    task automatic test_fright();
        do_reset();
        LC = 2'd2;
        park_ghosts();
        place_pac(200, 600);
        ghost_fright = 4'b0100;
        place_ghost(2, 197, 604);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (ghost_eaten !== 4'b0100 || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL fright_eat: got eaten=%b fail=%b want 0100 0", ghost_eaten, fail);
        end
        advance(); #1;
        vectors++;
        if (ghost_eaten !== 4'b0000 || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL fright_eat_width: got eaten=%b fail=%b want 0000 0", ghost_eaten, fail);
        end
        place_ghost(0, 203, 600);
        frame_tick = 1'b1; advance(); frame_tick = 1'b0; #1;
        vectors++;
        if (ghost_eaten !== 4'b0000 || fail !== 1'b1) begin
            miscompares++;
            $display("FAIL death_wins: got eaten=%b fail=%b want 0000 1", ghost_eaten, fail);
        end
        ghost_fright = '0;
    endtask
`endif

    task automatic test_random();
        int px, py;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                Reset_n = 1'b0;
                model_reset();
                #1;
                vectors++;
                if (outs !== 9'd0) begin
                    miscompares++;
                    $display("FAIL random_reset cycle %0d: got %b want %b", cyc, outs, 9'd0);
                end
                Reset_n = 1'b1;
            end
            frame_tick = ($urandom_range(0, 2) == 0);
            start      = ($urandom_range(0, 9) == 0);
            LC         = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
                place_pac(px, py);
            end else begin
                px = int'(pac_xy[19:10]);
                py = int'(pac_xy[9:0]);
            end
            for (int g = 0; g < NG; g++) begin
                if ($urandom_range(0, 3) == 0)
                    place_ghost(g, (px + int'($urandom_range(0, 24)) - 12) & 1023,
                                   (py + int'($urandom_range(0, 24)) - 12) & 1023);
                else
                    place_ghost(g, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
`ifdef FRIGHT_EAT_EN
            ghost_fright = NG'($urandom_range(0, (1 << NG) - 1));
`endif
            #1;
            model_outputs();
            vectors++;
            if (outs !== exp_outs) begin
                miscompares++;
                $display("FAIL random_outs cycle %0d: got %b want %b", cyc, outs, exp_outs);
            end
`ifdef FRIGHT_EAT_EN
            vectors++;
            if (ghost_eaten !== m_eaten) begin
                miscompares++;
                $display("FAIL random_eaten cycle %0d: got %b want %b", cyc, ghost_eaten, m_eaten);
            end
`endif
            advance();
        end
        frame_tick = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clock);
        test_reset();
        test_hit_respawn();
        test_boundary();
        test_last_life();
        test_grace_ignore();
        test_multi_hit();
`ifdef FRIGHT_EAT_EN
        test_fright();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/death_sequencer.md
Name: death_sequencer

Overview:
- Collision-to-life-loss controller for the Pacman game core.
- On each frame it checks Pacman against every ghost. On a hit it sends a one-cycle fail pulse to the life counter and freezes play for the death animation.
- After the animation it respawns Pacman with a grace period, or enters game over if the hit used the last life.
- It consumes the life counter's LC output and drives its fail and reload inputs, so it is the other end of the life-counter interface.

Parameters:
- NUM_GHOSTS, 4, number of ghosts checked.
- HIT_RADIUS, 8, a hit occurs when |dx| < HIT_RADIUS and |dy| < HIT_RADIUS, in pixels.
- DEATH_FRAMES, 64, number of frame_ticks spent in DYING.
- GRACE_FRAMES, 120, number of frame_ticks of invulnerability after respawn.

Ports:
- clock  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  restart request; honoured only in GAME_OVER.
- pac_xy  in  20  Pacman position: {x[9:0], y[9:0]}, unsigned.
- ghost_xy  in  20*NUM_GHOSTS  ghost i occupies bits [20i+19:20i], same format as pac_xy.
- LC  in  2  lives remaining, from the life counter.
- fail  out  1  one-cycle pulse to the life counter's fail input.
- lc_reload  out  1  one-cycle pulse to the life counter's Reset input.
- freeze  out  1  halts all sprite movement.
- respawn  out  1  one-cycle pulse; the position logic reloads start positions.
- grace  out  1  high during the invulnerability window.
- game_over  out  1  level, high while in GAME_OVER.
- anim_frame  out  3  death animation frame index.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=PLAY, counters=0, last_life=0.
  - All outputs 0.
  - Reset may assert in any state; the block returns to PLAY immediately, with no pending pulses.
- Collision test:
  - Combinational, per ghost: 11-bit absolute difference of x and of y.
  - hit_any = OR over ghosts of (dx < HIT_RADIUS AND dy < HIT_RADIUS).
  - No wrap-around: coordinates are unsigned, so a difference across the 0/1023 edge is large.
- State PLAY:
  - On a cycle with frame_tick=1 and hit_any=1, go to HIT.
  - hit_any is ignored on all other cycles.
- State HIT (exactly 1 cycle):
  - fail=1 and freeze=1.
  - Latch last_life = (LC==0). LC here is the pre-decrement value, because the life counter registers fail on the next edge.
  - Next state: DYING, with the frame counter cleared.
- State DYING:
  - freeze=1.
  - Count frame_ticks; anim_frame = cnt[5:3] (cnt scaled so 8 frames span DEATH_FRAMES).
  - When cnt reaches DEATH_FRAMES-1 on a frame_tick: go to GAME_OVER if last_life=1, else RESPAWN.
- State RESPAWN (1 cycle):
  - respawn=1 and freeze=1.
  - Next state: GRACE, with the counter cleared.
- State GRACE:
  - grace=1, freeze=0; collisions are ignored.
  - After GRACE_FRAMES frame_ticks, go to PLAY.
- State GAME_OVER:
  - game_over=1 and freeze=1.
  - On start=1: pulse lc_reload for 1 cycle, then go to RESPAWN. The life counter then holds 2.
  - start is ignored in every other state.
- Pulse and level rules:
  - fail, respawn and lc_reload are each high for exactly one cycle per event.
  - fail is never asserted in GAME_OVER, DYING or GRACE.
  - anim_frame=0 outside DYING.
- Simultaneous hits by several ghosts in one frame produce a single fail.
- A frame_tick arriving in HIT or RESPAWN is not counted.
- Counter width: ceil(log2(max(DEATH_FRAMES, GRACE_FRAMES))) bits. The counter saturates and never wraps.

Optional Feature:
- Macro: FRIGHT_EAT_EN.
- When defined:
  - Adds input ghost_fright[NUM_GHOSTS-1:0] and output ghost_eaten[NUM_GHOSTS-1:0].
  - In PLAY, on a frame_tick, a collision with a frightened ghost pulses that ghost's ghost_eaten bit for 1 cycle and causes no death.
  - If a frightened and a non-frightened ghost both collide in the same frame, death wins and ghost_eaten stays 0.
- When not defined: the ports are absent and every collision is lethal.

Test Plan:
- Reset, then place Pacman at (100,100) and ghost0 at (104,103); assert frame_tick. Expect fail high for exactly 1 cycle and freeze=1. With LC=2, respawn pulses after 64 frame_ticks, followed by grace for 120 frames.
- Ghost at (108,100), Pacman at (100,100) (dx=8=HIT_RADIUS). Expect no fail. A collision present only on cycles without frame_tick also gives no fail.
- LC=0 at the hit. Expect fail pulse, DYING for 64 frames, then game_over=1 held. start=1 gives a 1-cycle lc_reload pulse, then respawn, then grace.
- During GRACE, overlap a ghost for 10 frames. Expect no fail. Once back in PLAY, the overlap produces fail on the next frame_tick.
- Two ghosts overlapping in the same frame produce a single fail pulse. Asserting Reset_n=0 mid-DYING gives all outputs 0 immediately and state PLAY.
- With FRIGHT_EAT_EN: frightened ghost2 colliding gives ghost_eaten=4'b0100 for 1 cycle and no fail. Adding a non-frightened ghost0 collision in the same frame gives fail and ghost_eaten=0.
